dual_issue_arbiter: RTL

- Sits between decode and the instruction dispatch stage. Accepts an in-order instruction pair per cycle: slot A is older, slot B is younger.
- The load-store unit is a single shared unit. The branch unit and reg unit read only dispatch slot A.
- The block detects structural conflicts on these units, serialises conflicting pairs over multiple cycles and back-pressures decode.
- It presents conflict-free, registered slot A/B issue bundles to dispatch.

---
 rtl/dual_issue_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dual_issue_arbiter.sv
// Dual-issue arbiter between decode and dispatch.
// Takes an in-order instruction pair (A older, B younger) and issues it as
// conflict-free registered slot A/B bundles. Pairs that collide on the single
// load-store unit, or whose younger entry needs the slot-A-only branch/reg
// units, are split across cycles while decode is held off through ready_o.
module dual_issue_arbiter #(
  parameter int PAYLOAD_W = 47,
  parameter int CNT_W     = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 validA_i,
  input  logic                 validB_i,
  input  logic [1:0]           funcTypeA_i,
  input  logic [1:0]           funcTypeB_i,
  input  logic [PAYLOAD_W-1:0] payloadA_i,
  input  logic [PAYLOAD_W-1:0] payloadB_i,
  input  logic                 lsBusy_i,
  output logic                 ready_o,
  output logic                 enableA_o,
  output logic                 enableB_o,
  output logic [1:0]           funcTypeA_o,
  output logic [1:0]           funcTypeB_o,
  output logic [PAYLOAD_W-1:0] payloadA_o,
  output logic [PAYLOAD_W-1:0] payloadB_o,
  output logic [CNT_W-1:0]     splitCount_o
);

  // Arbiter states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD_AB = 2'd1;
  localparam logic [1:0] ST_HOLD_B  = 2'd2;

  // Unit classes
  localparam logic [1:0] FT_LS     = 2'd1;
  localparam logic [1:0] FT_BRANCH = 2'd2;
  localparam logic [1:0] FT_REG    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // True when the younger entry cannot share the cycle with the older one:
  // branch/reg units only listen to slot A, and there is one load-store unit.
  function automatic logic pair_conflict(input logic [1:0] ft_a, input logic [1:0] ft_b);
    logic hit;
    hit = (ft_b == FT_BRANCH) || (ft_b == FT_REG) || ((ft_a == FT_LS) && (ft_b == FT_LS));
    return hit;
  endfunction

  logic [1:0]           state;
  logic                 hold_a_valid;
  logic [1:0]           hold_a_ft;
  logic [PAYLOAD_W-1:0] hold_a_pay;
  logic                 hold_b_valid;
  logic [1:0]           hold_b_ft;
  logic [PAYLOAD_W-1:0] hold_b_pay;

  logic                 accept;
  logic                 in_a_valid;
  logic [1:0]           in_a_ft;
  logic [PAYLOAD_W-1:0] in_a_pay;
  logic                 in_b_valid;

  logic                 pend_valid;
  logic [1:0]           pa_ft;
  logic [PAYLOAD_W-1:0] pa_pay;
  logic                 pb_valid;
  logic [1:0]           pb_ft;
  logic [PAYLOAD_W-1:0] pb_pay;

  logic [1:0]           nxt_state;
  logic                 issue_a;
  logic                 issue_b;
  logic                 split_inc;
  logic                 nxt_hold_a_valid;
  logic [1:0]           nxt_hold_a_ft;
  logic [PAYLOAD_W-1:0] nxt_hold_a_pay;
  logic                 nxt_hold_b_valid;
  logic [1:0]           nxt_hold_b_ft;
  logic [PAYLOAD_W-1:0] nxt_hold_b_pay;

  // Input acceptance and compaction: a lone B moves into position A.
  always_comb begin
    accept     = ready_o & (validA_i | validB_i) & ~flush_i;
    in_a_valid = validA_i | validB_i;
    in_b_valid = validA_i & validB_i;
    if (validA_i) begin
      in_a_ft  = funcTypeA_i;
      in_a_pay = payloadA_i;
    end else begin
      in_a_ft  = funcTypeB_i;
      in_a_pay = payloadB_i;
    end
  end

  // Select the pending pair: fresh input in IDLE, held entries otherwise.
  always_comb begin
    pend_valid = 1'b0;
    pa_ft      = 2'd0;
    pa_pay     = '0;
    pb_valid   = 1'b0;
    pb_ft      = 2'd0;
    pb_pay     = '0;
    if (state == ST_IDLE) begin
      pend_valid = accept & in_a_valid;
      pa_ft      = in_a_ft;
      pa_pay     = in_a_pay;
      pb_valid   = in_b_valid;
      pb_ft      = funcTypeB_i;
      pb_pay     = payloadB_i;
    end else begin
      pend_valid = hold_a_valid;
      pa_ft      = hold_a_ft;
      pa_pay     = hold_a_pay;
      pb_valid   = hold_b_valid;
      pb_ft      = hold_b_ft;
      pb_pay     = hold_b_pay;
    end
  end

  // Issue decision: stall on busy LS, split on conflict or busy LS for B,
  // otherwise issue the whole pair. Flush discards everything.
  always_comb begin
    nxt_state        = ST_IDLE;
    issue_a          = 1'b0;
    issue_b          = 1'b0;
    split_inc        = 1'b0;
    nxt_hold_a_valid = 1'b0;
    nxt_hold_a_ft    = 2'd0;
    nxt_hold_a_pay   = '0;
    nxt_hold_b_valid = 1'b0;
    nxt_hold_b_ft    = 2'd0;
    nxt_hold_b_pay   = '0;
    if (flush_i) begin
      nxt_state = ST_IDLE;
    end else if (pend_valid) begin
      if ((pa_ft == FT_LS) && lsBusy_i) begin
        // Older entry cannot go; keep both in program order.
        nxt_state        = ST_HOLD_AB;
        nxt_hold_a_valid = 1'b1;
        nxt_hold_a_ft    = pa_ft;
        nxt_hold_a_pay   = pa_pay;
        nxt_hold_b_valid = pb_valid;
        nxt_hold_b_ft    = pb_valid ? pb_ft : 2'd0;
        nxt_hold_b_pay   = pb_valid ? pb_pay : '0;
      end else if (pb_valid && pair_conflict(pa_ft, pb_ft)) begin
        // Structural split: B is relocated to position A for next cycle.
        nxt_state        = ST_HOLD_B;
        issue_a          = 1'b1;
        split_inc        = 1'b1;
        nxt_hold_a_valid = 1'b1;
        nxt_hold_a_ft    = pb_ft;
        nxt_hold_a_pay   = pb_pay;
      end else if (pb_valid && (pb_ft == FT_LS) && lsBusy_i) begin
        // B waits only for the LS unit; not counted as a conflict split.
        nxt_state        = ST_HOLD_B;
        issue_a          = 1'b1;
        nxt_hold_a_valid = 1'b1;
        nxt_hold_a_ft    = pb_ft;
        nxt_hold_a_pay   = pb_pay;
      end else begin
        nxt_state = ST_IDLE;
        issue_a   = 1'b1;
        issue_b   = pb_valid;
      end
    end else begin
      nxt_state = ST_IDLE;
    end
  end

  // State, held entries, registered issue bundles, ready and split counter.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state        <= ST_IDLE;
      hold_a_valid <= 1'b0;
      hold_a_ft    <= 2'd0;
      hold_a_pay   <= '0;
      hold_b_valid <= 1'b0;
      hold_b_ft    <= 2'd0;
      hold_b_pay   <= '0;
      ready_o      <= 1'b1;
      enableA_o    <= 1'b0;
      enableB_o    <= 1'b0;
      funcTypeA_o  <= 2'd0;
      funcTypeB_o  <= 2'd0;
      payloadA_o   <= '0;
      payloadB_o   <= '0;
      splitCount_o <= '0;
    end else begin
      state        <= nxt_state;
      hold_a_valid <= nxt_hold_a_valid;
      hold_a_ft    <= nxt_hold_a_ft;
      hold_a_pay   <= nxt_hold_a_pay;
      hold_b_valid <= nxt_hold_b_valid;
      hold_b_ft    <= nxt_hold_b_ft;
      hold_b_pay   <= nxt_hold_b_pay;
      ready_o      <= (nxt_state == ST_IDLE);
      enableA_o    <= issue_a;
      enableB_o    <= issue_b;
      funcTypeA_o  <= issue_a ? pa_ft : 2'd0;
      funcTypeB_o  <= issue_b ? pb_ft : 2'd0;
      payloadA_o   <= issue_a ? pa_pay : '0;
      payloadB_o   <= issue_b ? pb_pay : '0;
      if (split_inc && (splitCount_o != CNT_MAX)) begin
        splitCount_o <= splitCount_o + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        splitCount_o <= splitCount_o;
      end
    end
  end

endmodule
